// File: rtl/mode_sequencer.sv
// Steps MAIN_MODE over a latched range with optional SUB_MODE[0] sweep.
// Define MODE_SEQ_LOOP_EN to wrap back to FIRST_MODE instead of finishing.
module mode_sequencer #(
  parameter int unsigned SETTLE  = 8,
  parameter int unsigned DWELL_W = 16
) (
  input  logic               CLK,
  input  logic               RSTX,
  input  logic               START,
  input  logic               ABORT,
  input  logic [7:0]         FIRST_MODE,
  input  logic [7:0]         LAST_MODE,
  input  logic [DWELL_W-1:0] DWELL,
  input  logic               SUB_SWEEP,
  output logic [7:0]         MAIN_MODE,
  output logic [7:0]         SUB_MODE,
  output logic               CLR,
  output logic               MEAS_EN,
  output logic               STEP_DONE,
  output logic               BUSY,
  output logic               DONE,
  output logic               BAD_CFG
);

  localparam int CW = (DWELL_W > 8) ? DWELL_W : 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_SETTLE,
    S_MEAS,
    S_NEXT
  } state_t;

  state_t state_q, state_d;

  logic [7:0]         last_q;
  logic               sweep_q;
  logic [DWELL_W-1:0] dwell_q;
`ifdef MODE_SEQ_LOOP_EN
  logic [7:0]         first_q;
`endif

  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    mode_d;
  logic          sub_d;
  logic          done_d;
  logic          bad_d;
  logic          go;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = MAIN_MODE;
    sub_d   = SUB_MODE[0];
    bad_d   = 1'b0;
    go      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (START && !ABORT) begin
          if (FIRST_MODE > LAST_MODE) begin
            bad_d = 1'b1;
          end else begin
            go      = 1'b1;
            state_d = S_CLEAR;
            mode_d  = FIRST_MODE;
            sub_d   = 1'b0;
          end
        end
      end
      S_CLEAR: begin
        state_d = S_SETTLE;
        cnt_d   = CW'(SETTLE - 1);
      end
      S_SETTLE: begin
        if (cnt_q == '0) begin
          state_d = S_MEAS;
          cnt_d   = CW'(dwell_q) - CW'(1);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_MEAS: begin
        if (cnt_q == '0) state_d = S_NEXT;
        else cnt_d = cnt_q - CW'(1);
      end
      S_NEXT: begin
        state_d = S_CLEAR;
        if (sweep_q && !SUB_MODE[0]) begin
          sub_d = 1'b1;
        end else if (MAIN_MODE != last_q) begin
          mode_d = MAIN_MODE + 8'd1;
          sub_d  = 1'b0;
        end else begin
`ifdef MODE_SEQ_LOOP_EN
          mode_d  = first_q;
          sub_d   = 1'b0;
`else
          state_d = S_IDLE;
          mode_d  = 8'd0;
          sub_d   = 1'b0;
`endif
        end
      end
      default: begin
        state_d = S_IDLE;
        mode_d  = 8'd0;
        sub_d   = 1'b0;
      end
    endcase
    if (ABORT && state_q != S_IDLE) begin
      state_d = S_IDLE;
      mode_d  = 8'd0;
      sub_d   = 1'b0;
    end
    // DONE rides along with the STEP_DONE of the final step
    done_d = (state_d == S_NEXT) &&
             !(sweep_q && !sub_d) &&
             (mode_d == last_q);
  end

  always_ff @(posedge CLK) begin
    if (!RSTX) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      last_q    <= '0;
      sweep_q   <= 1'b0;
      dwell_q   <= '0;
`ifdef MODE_SEQ_LOOP_EN
      first_q   <= '0;
`endif
      MAIN_MODE <= '0;
      SUB_MODE  <= '0;
      CLR       <= 1'b0;
      MEAS_EN   <= 1'b0;
      STEP_DONE <= 1'b0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      BAD_CFG   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (go) begin
        last_q  <= LAST_MODE;
        sweep_q <= SUB_SWEEP;
        dwell_q <= (DWELL == '0) ? DWELL_W'(1) : DWELL;
`ifdef MODE_SEQ_LOOP_EN
        first_q <= FIRST_MODE;
`endif
      end
      MAIN_MODE <= mode_d;
      SUB_MODE  <= {7'd0, sub_d};
      CLR       <= (state_d == S_CLEAR);
      MEAS_EN   <= (state_d == S_MEAS);
      STEP_DONE <= (state_d == S_NEXT);
      BUSY      <= (state_d != S_IDLE);
      DONE      <= done_d;
      BAD_CFG   <= bad_d;
    end
  end

endmodule
